// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller: die codes, per-die lookups,
// LFSR tap masks and the FSM state type.
package dice_pkg;

  localparam logic [2:0] DIE_D2   = 3'd0;
  localparam logic [2:0] DIE_D4   = 3'd1;
  localparam logic [2:0] DIE_D6   = 3'd2;
  localparam logic [2:0] DIE_D8   = 3'd3;
  localparam logic [2:0] DIE_D10  = 3'd4;
  localparam logic [2:0] DIE_D12  = 3'd5;
  localparam logic [2:0] DIE_D20  = 3'd6;
  localparam logic [2:0] DIE_D100 = 3'd7;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [6:0] die_sides(input logic [2:0] code);
    case (code)
      DIE_D2:  return 7'd2;
      DIE_D4:  return 7'd4;
      DIE_D6:  return 7'd6;
      DIE_D8:  return 7'd8;
      DIE_D10: return 7'd10;
      DIE_D12: return 7'd12;
      DIE_D20: return 7'd20;
      default: return 7'd100;
    endcase
  endfunction

  // Smallest candidate width that covers every face of the die.
  function automatic logic [2:0] die_mask_w(input logic [2:0] code);
    case (code)
      DIE_D2:  return 3'd1;
      DIE_D4:  return 3'd2;
      DIE_D6:  return 3'd3;
      DIE_D8:  return 3'd3;
      DIE_D10: return 3'd4;
      DIE_D12: return 3'd4;
      DIE_D20: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running right-shift Galois LFSR with seed load; a zero load value is
// replaced by SEED so the register can never lock up at all-zeros.
module lfsr_core
  import dice_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = DEFAULT_SEED[W-1:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  localparam logic [31:0]  TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q >> 1;
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end else if (state_q[0]) begin
      state_d = (state_q >> 1) ^ TAPS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dice_roller.sv
// Dice-roll engine: rejection-samples the LFSR into unbiased die faces and
// sums one to eight dice per request, reporting the total with a valid pulse.
module dice_roller
  import dice_pkg::*;
#(
  parameter int          LFSR_W = 16,
  parameter logic [31:0] SEED   = DEFAULT_SEED,
  parameter int          SUM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              roll_req,
  input  logic [2:0]        die_sel,
  input  logic [2:0]        num_dice,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  output logic [SUM_W-1:0]  result,
  output logic              result_valid,
  output logic [7:0]        rejects
);

  if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 32) begin : g_bad_lfsr_w
    $error("dice_roller: LFSR_W must be 8, 16, 24 or 32");
  end
  if (SUM_W < 10) begin : g_bad_sum_w
    $error("dice_roller: SUM_W must be at least 10");
  end
  if (SEED[LFSR_W-1:0] == '0) begin : g_bad_seed
    $error("dice_roller: SEED must be nonzero in its low LFSR_W bits");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr_hi;

  lfsr_core #(
    .W    (LFSR_W),
    .SEED (SEED[LFSR_W-1:0])
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:7];

  state_e           state_q, state_d;
  logic [SUM_W-1:0] result_q, result_d;
  logic [7:0]       rejects_q, rejects_d;
  logic             valid_q, valid_d;
  logic [2:0]       die_q, die_d;
  logic [2:0]       nd_q, nd_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       rej_q, rej_d;

  logic [2:0] mask_w;
  logic [6:0] mask;
  logic [6:0] sides;
  logic [6:0] cand;
  logic       hit;

  // Candidate comes from the register value, so a draw sees whatever the
  // LFSR holds during that DRAW cycle (including a freshly loaded seed).
  assign sides  = die_sides(die_q);
  assign mask_w = die_mask_w(die_q);
  assign mask   = 7'((8'd1 << mask_w) - 8'd1);
  assign cand   = lfsr[6:0] & mask;
  assign hit    = (cand < sides);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    rejects_d = rejects_q;
    valid_d   = 1'b0;
    die_d     = die_q;
    nd_d      = nd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rej_d     = rej_q;
    case (state_q)
      ST_IDLE: begin
        if (roll_req) begin
          die_d   = die_sel;
          nd_d    = num_dice;
          acc_d   = '0;
          cnt_d   = '0;
          rej_d   = '0;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (hit) begin
          acc_d = acc_q + SUM_W'(cand) + SUM_W'(1);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == nd_q) begin
            state_d = ST_DONE;
          end
        end else begin
          rej_d = sat_inc8(rej_q);
        end
      end
      ST_DONE: begin
        result_d  = acc_q;
        rejects_d = rej_q;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      rejects_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rejects_q <= rejects_d;
      valid_q   <= valid_d;
    end
  end

  // Roll working registers are always initialised on acceptance.
  always_ff @(posedge clk) begin
    die_q <= die_d;
    nd_q  <= nd_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
    rej_q <= rej_d;
  end

  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign rejects      = rejects_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: hand-computed roll vectors plus sequences
// for held requests, mid-roll reset and mid-roll seed reload.
module tb_dice_roller;

  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        roll_req = 1'b0;
  logic        seed_load = 1'b0;
  logic [2:0]  die_sel = 3'd0;
  logic [2:0]  num_dice = 3'd0;
  logic [15:0] seed_in = 16'h0000;
  logic        busy;
  logic [9:0]  result;
  logic        result_valid;
  logic [7:0]  rejects;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] seed;
    logic [2:0]  die;
    logic [2:0]  nd;
    int          exp_sum;
    int          exp_rej;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  dice_roller #(
    .LFSR_W (16),
    .SEED   (32'h0000_ACE1),
    .SUM_W  (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .roll_req     (roll_req),
    .die_sel      (die_sel),
    .num_dice     (num_dice),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .rejects      (rejects)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns sum, rejects and
  // the number of edges from acceptance until result_valid is seen.
  task automatic do_roll(input logic [2:0] die, input logic [2:0] nd, input bit load,
                         input logic [15:0] seed, output int sum, output int rej,
                         output int lat);
    die_sel   = die;
    num_dice  = nd;
    seed_load = load;
    seed_in   = seed;
    roll_req  = 1'b1;
    @(posedge clk); #1;
    roll_req  = 1'b0;
    seed_load = 1'b0;
    die_sel   = ~die;
    num_dice  = ~nd;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!result_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_seen", result_valid, 1);
    check("busy_at_valid", busy, 0);
    sum = int'(result);
    rej = int'(rejects);
    @(posedge clk); #1;
    check("valid_one_cycle", result_valid, 0);
  endtask

  initial begin
    int sum, rej, lat, pulses, gap, rej_hits, rej_total, pulse_lat;

    vecs[0]  = '{16'hACE1, 3'd3, 3'd0,   2, 0, 2};
    vecs[1]  = '{16'h0001, 3'd0, 3'd0,   2, 0, 2};
    vecs[2]  = '{16'h0001, 3'd3, 3'd3,   5, 0, 5};
    vecs[3]  = '{16'h0001, 3'd2, 3'd1,   3, 0, 3};
    vecs[4]  = '{16'h0007, 3'd2, 3'd0,   4, 1, 3};
    vecs[5]  = '{16'h007F, 3'd7, 3'd0,  64, 1, 3};
    vecs[6]  = '{16'h001F, 3'd6, 3'd1,  24, 1, 4};
    vecs[7]  = '{16'h000F, 3'd4, 3'd0,   8, 1, 3};
    vecs[8]  = '{16'h001E, 3'd5, 3'd0,   8, 2, 4};
    vecs[9]  = '{16'h0003, 3'd1, 3'd2,   7, 0, 4};
    vecs[10] = '{16'hFFFF, 3'd3, 3'd7,  64, 0, 9};
    vecs[11] = '{16'h0064, 3'd7, 3'd0,  51, 1, 3};
    vecs[12] = '{16'h0063, 3'd7, 3'd0, 100, 0, 2};
    vecs[13] = '{16'h0001, 3'd0, 3'd7,   9, 0, 9};

    repeat (2) @(posedge clk);
    #1;
    check("rst_lfsr", dut.lfsr, 16'hACE1);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_rejects", rejects, 0);
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("zero_seed_subst", dut.lfsr, 16'hACE1);
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("seed_load", dut.lfsr, 16'h1234);
    @(posedge clk); #1;
    check("idle_step", dut.lfsr, 16'h091A);

    for (int i = 0; i < 14; i++) begin
      do_roll(vecs[i].die, vecs[i].nd, 1'b1, vecs[i].seed, sum, rej, lat);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_rejects", i), rej, vecs[i].exp_rej);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    for (int r = 0; r < 100; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      do_roll(3'd2, 3'd7, 1'b0, 16'h0000, sum, rej, lat);
      check("d6x8_range", (sum >= 8 && sum <= 48), 1);
      check("d6x8_latency", lat, 9 + rej);
    end

    rej_hits  = 0;
    rej_total = 0;
    for (int r = 0; r < 200; r++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      do_roll(3'd7, 3'd0, 1'b0, 16'h0000, sum, rej, lat);
      check("d100_range", (sum >= 1 && sum <= 100), 1);
      check("d100_latency", lat, 2 + rej);
      if (rej > 0) rej_hits++;
      rej_total += rej;
    end
    check("d100_any_reject", (rej_hits > 0), 1);
    check("d100_reject_mean", (rej_total >= 30 && rej_total <= 90), 1);

    // Reset in the middle of an 8-die roll
    die_sel  = 3'd2;
    num_dice = 3'd7;
    roll_req = 1'b1;
    @(posedge clk); #1;
    roll_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_roll", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_rejects", rejects, 0);
    check("midrst_lfsr", dut.lfsr, 16'hACE1);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0);

    // roll_req held high while die_sel/num_dice change under a running roll
    die_sel   = 3'd0;
    num_dice  = 3'd3;
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    roll_req  = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    pulses    = 0;
    pulse_lat = 0;
    sum       = -1;
    for (int c = 1; c <= 10; c++) begin
      die_sel  = die_sel ^ 3'b111;
      num_dice = 3'd7;
      @(posedge clk); #1;
      if (result_valid) begin
        pulses++;
        sum       = int'(result);
        pulse_lat = c;
        roll_req  = 1'b0;
      end
    end
    roll_req = 1'b0;
    check("held_pulses", pulses, 1);
    check("held_sum", sum, 5);
    check("held_latency", pulse_lat, 5);

    // Seed reload during DRAW
    die_sel   = 3'd3;
    num_dice  = 3'd3;
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    roll_req  = 1'b1;
    @(posedge clk); #1;
    roll_req  = 1'b0;
    seed_load = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    lat++;
    seed_in   = 16'h0007;
    seed_load = 1'b1;
    @(posedge clk); #1;
    lat++;
    seed_load = 1'b0;
    while (!result_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("reload_valid_seen", result_valid, 1);
    check("reload_sum", result, 15);
    check("reload_rejects", rejects, 0);
    check("reload_latency", lat, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
